// File: rtl/tt_sel_pkg.sv
// Shared definitions for the project-select loader: FSM encoding, default
// address width and the glitch-filter counter width.
package tt_sel_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    ACTIVE = ST_ACTIVE
  } sel_state_e;

  localparam int DEF_ADDR_W = 10;

  // Wide enough to hold FILT_LEN itself.
  function automatic int filt_cnt_w(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/tt_sel_sync_filt.sv
// Synchronizer, glitch filter and edge detector for one asynchronous control pin.
// The filtered level only moves after FILT_LEN consecutive differing samples.
module tt_sel_sync_filt
  import tt_sel_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = filt_cnt_w(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   level_d_r;
  logic                   sample_s;

  assign sample_s = sync_r[SYNC_STAGES-1];

  // Input synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
    end
  end

  // Glitch filter: any agreeing sample restarts the run count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (sample_s != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_r <= sample_s;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  // One-cycle delay of the filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level_r;
    end
  end

  assign level = level_r;
  assign rise  = level_r & ~level_d_r;
  assign fall  = ~level_r & level_d_r;

endmodule

// File: rtl/tt_sel_addr_loader.sv
// Project-select front end: counts filtered sel_inc rises into a saturating
// address and issues a one-cycle load strobe when sel_ena is raised.
module tt_sel_addr_loader
  import tt_sel_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_inc,
  input  logic              sel_ena,
  output logic [ADDR_W-1:0] addr,
  output logic              load,
  output logic              ena_o,
  output logic              ovf
);

  sel_state_e        state_r;
  sel_state_e        next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic              ovf_r;
  logic              ovf_s;
  logic              load_r;
  logic              ena_r;

  logic inc_level_s, inc_rise_s, inc_fall_s;
  logic ena_level_s, ena_rise_s, ena_fall_s;
  logic unused_inc_s;

  tt_sel_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_inc_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sel_inc),
    .level (inc_level_s),
    .rise  (inc_rise_s),
    .fall  (inc_fall_s)
  );

  tt_sel_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_ena_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sel_ena),
    .level (ena_level_s),
    .rise  (ena_rise_s),
    .fall  (ena_fall_s)
  );

  // Only the rising edge of sel_inc is meaningful.
  assign unused_inc_s = inc_level_s ^ inc_fall_s;

  // Next-state, counter and overflow logic.
  always_comb begin
    next_s = state_r;
    addr_s = addr_r;
    ovf_s  = ovf_r;
    case (state_r)
      IDLE: begin
        if (inc_rise_s) begin
          if (&addr_r) begin
            ovf_s = 1'b1;
          end else begin
            addr_s = addr_r + ADDR_W'(1);
          end
        end else begin
          addr_s = addr_r;
        end
        if (ena_rise_s) begin
          next_s = LOAD;
        end else begin
          next_s = IDLE;
        end
      end
      LOAD: begin
        if (ena_level_s) begin
          next_s = ACTIVE;
        end else begin
          next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ena_fall_s) begin
          next_s = IDLE;
        end else begin
          next_s = ACTIVE;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= '0;
      ovf_r   <= 1'b0;
      load_r  <= 1'b0;
      ena_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      addr_r  <= addr_s;
      ovf_r   <= ovf_s;
      load_r  <= (next_s == LOAD);
      ena_r   <= (next_s == ACTIVE);
    end
  end

  assign addr  = addr_r;
  assign load  = load_r;
  assign ena_o = ena_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_tt_sel_addr_loader.sv
// Randomized scoreboard bench for tt_sel_addr_loader: a transaction-level
// model predicts addr/ovf/enable and the address carried by each load strobe.
module tb_tt_sel_addr_loader;

  localparam int AW   = 3;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int SETTLE = SYNC + FILT + 4;

  logic          clk;
  logic          rst_n;
  logic          sel_inc;
  logic          sel_ena;
  logic [AW-1:0] addr;
  logic          load;
  logic          ena_o;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  int  exp_q[$];
  int  m_addr;
  bit  m_ovf;
  bit  m_active;
  bit  follow_chk;
  bit  prev_load;
  int  load_addr;

  tt_sel_addr_loader #(
    .ADDR_W      (AW),
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_inc (sel_inc),
    .sel_ena (sel_ena),
    .addr    (addr),
    .load    (load),
    .ena_o   (ena_o),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a load strobe.
  always @(negedge clk) begin
    if (load) begin
      check("load_ena_exclusive", int'(ena_o), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_load", 1, 0);
      end else begin
        check("load_addr", int'(addr), exp_q.pop_front());
      end
      load_addr = int'(addr);
    end
    if (prev_load && follow_chk) check("ena_after_load", int'(ena_o), 1);
    if (ena_o && follow_chk) check("addr_stable_active", int'(addr), load_addr);
    prev_load = load;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_inc();
    if (!m_active) begin
      if (m_addr == (1 << AW) - 1) m_ovf = 1'b1;
      else m_addr = m_addr + 1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_addr"}, int'(addr), m_addr);
    check({tag, "_ovf"}, int'(ovf), int'(m_ovf));
    check({tag, "_ena"}, int'(ena_o), int'(m_active));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sel_inc = 1'b0; sel_ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = 0; m_ovf = 1'b0; m_active = 1'b0;
  endtask

  task automatic inc_pulse(input int h);
    @(negedge clk);
    sel_inc = 1'b1;
    model_inc();
    hold(h);
    sel_inc = 1'b0;
    hold(SETTLE);
  endtask

  task automatic glitch(input int g);
    @(negedge clk);
    sel_inc = 1'b1;
    hold(g);
    sel_inc = 1'b0;
    hold(SETTLE);
  endtask

  // Drive sel_ena; optionally measure edges from the first sampling edge to the response.
  task automatic ena_set(input logic v, input bit measure);
    int n;
    bit found;
    @(negedge clk);
    sel_ena = v;
    if (v && !m_active) begin
      exp_q.push_back(m_addr);
      m_active = 1'b1;
    end else if (!v) begin
      m_active = 1'b0;
    end
    if (measure) begin
      n = 0; found = 1'b0;
      while (!found && n < 40) begin
        @(posedge clk); #1;
        if (v ? load : !ena_o) found = 1'b1;
        else n++;
      end
      check(v ? "load_latency" : "ena_fall_latency", found ? n : 99, SYNC + FILT);
    end
    hold(SETTLE);
  endtask

  task automatic both_rise();
    @(negedge clk);
    sel_inc = 1'b1; sel_ena = 1'b1;
    model_inc();
    exp_q.push_back(m_addr);
    m_active = 1'b1;
    hold(SETTLE);
    sel_inc = 1'b0;
    hold(SETTLE);
  endtask

  initial begin
    int n;
    int op;
    bit found;
    rst_n = 1'b0; sel_inc = 1'b0; sel_ena = 1'b0;
    follow_chk = 1'b1; prev_load = 1'b0; load_addr = 0;
    m_addr = 0; m_ovf = 1'b0; m_active = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_load", int'(load), 0);
    check_state("reset");

    // Three clean pulses then enable: load carries addr 3.
    for (int i = 0; i < 3; i++) inc_pulse(8);
    check("three_inc_addr", int'(addr), 3);
    ena_set(1'b1, 1'b1);
    check_state("active3");

    // Increments are ignored while active; drop and re-raise enable.
    inc_pulse(8);
    check_state("active_inc");
    ena_set(1'b0, 1'b1);
    check_state("idle_after_fall");
    ena_set(1'b1, 1'b0);
    ena_set(1'b0, 1'b0);

    // Sub-threshold glitch leaves everything unchanged.
    glitch(FILT - 1);
    check_state("glitch");

    // Saturation and overflow, then reset clears both.
    do_reset();
    for (int i = 0; i < 9; i++) inc_pulse(FILT + 1);
    check("sat_addr", int'(addr), 7);
    check("sat_ovf", int'(ovf), 1);
    do_reset();
    #1;
    check_state("post_sat_reset");

    // Simultaneous rises from addr 4: load carries 5.
    for (int i = 0; i < 4; i++) inc_pulse(FILT);
    both_rise();
    check_state("both_rise");
    ena_set(1'b0, 1'b0);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: inc_pulse($urandom_range(FILT, FILT + 6));
        1: glitch($urandom_range(1, FILT - 1));
        2: ena_set(!sel_ena, 1'b0);
        3: if (!sel_ena) both_rise(); else inc_pulse(FILT);
        default: if (!sel_ena) do_reset(); else glitch(1);
      endcase
      #1;
      check_state("rand");
    end
    if (sel_ena) ena_set(1'b0, 1'b0);

    // Reset during LOAD wins over everything.
    do_reset();
    inc_pulse(FILT);
    follow_chk = 1'b0;
    @(negedge clk);
    sel_ena = 1'b1;
    exp_q.push_back(m_addr);
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (load) found = 1'b1;
      else n++;
    end
    check("load_before_reset", int'(found), 1);
    rst_n = 1'b0; sel_ena = 1'b0;
    @(posedge clk); #1;
    check("rst_in_load_load", int'(load), 0);
    check("rst_in_load_ena", int'(ena_o), 0);
    check("rst_in_load_addr", int'(addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = 0; m_ovf = 1'b0; m_active = 1'b0;
    hold(SETTLE);
    check_state("after_rst_in_load");
    follow_chk = 1'b1;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
